// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit sitting in front of a single `mem`.
//
// Accepts byte-addressed BYTE/HALF/WORD loads and stores from the core and
// makes sure `mem` only ever sees naturally aligned accesses. A misaligned
// request becomes two aligned WORD reads; a misaligned store then writes back
// two merged WORDs.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_write, req_width,
//   req_sign_extend,
//   req_address, req_data      request fields, latched at acceptance
//   resp_valid                 one-cycle completion pulse
//   resp_data, resp_error      load result (0 for stores) and fault flag,
//                              held until the next completion
//   mem_*                      initiator side of the attached `mem`

package lsu_align_pkg;
  localparam int DMemAddrWidth = 16;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_width_t;
endpackage

module lsu_align
  import lsu_align_pkg::*;
#(
  parameter int AddrWidth = DMemAddrWidth
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  mem_width_t           req_width,
  input  logic                 req_sign_extend,
  input  logic [AddrWidth-1:0] req_address,
  input  logic [31:0]          req_data,
  output logic                 resp_valid,
  output logic [31:0]          resp_data,
  output logic                 resp_error,
  output logic                 mem_write_enable,
  output mem_width_t           mem_width,
  output logic                 mem_sign_extend,
  output logic [AddrWidth-1:0] mem_address,
  output logic [31:0]          mem_data_in,
  input  logic [31:0]          mem_data_out,
  input  logic                 mem_alignment_error
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, DONE} state_e;

  state_e               state_q, state_d;
  logic                 write_q;
  mem_width_t           width_q;
  logic                 sext_q;
  logic [AddrWidth-1:0] addr_q;
  logic [31:0]          data_q;
  logic [31:0]          w0_q, w0_d;
  logic [31:0]          w1_q, w1_d;
  logic                 err_q, err_d;
  logic [31:0]          resp_data_q, resp_data_d;
  logic                 resp_error_q, resp_error_d;

  logic                 accept;
  logic                 reqMisaligned;
  logic                 misaligned;
  logic [1:0]           offset;
  logic [4:0]           shiftAmt;
  logic [AddrWidth-1:0] baseAddr;
  logic [AddrWidth-1:0] nextAddr;
  logic [31:0]          lowMask;
  logic [31:0]          loadWindow;
  logic [31:0]          loadRaw;
  logic                 signBit;
  logic [31:0]          loadResult;
  logic [63:0]          merged;
  logic                 errSoFar;

  assign reqMisaligned = (req_width == HALF && req_address[0]) ||
                         (req_width == WORD && req_address[1:0] != 2'b00);

  assign offset     = addr_q[1:0];
  assign shiftAmt   = {offset, 3'b000};
  assign misaligned = (width_q == HALF && offset[0]) ||
                      (width_q == WORD && offset != 2'b00);

  // The second word address wraps modulo the address space on purpose.
  assign baseAddr = {addr_q[AddrWidth-1:2], 2'b00};
  assign nextAddr = baseAddr + AddrWidth'(4);

  always_comb begin
    lowMask = 32'hFFFF_FFFF;
    case (width_q)
      BYTE:    lowMask = 32'h0000_00FF;
      HALF:    lowMask = 32'h0000_FFFF;
      default: lowMask = 32'hFFFF_FFFF;
    endcase
  end

  // Misaligned load result: the second word comes straight off the
  // combinational read in RD1, so it is never registered for loads.
  assign loadWindow = 32'({mem_data_out, w0_q} >> shiftAmt);
  assign loadRaw    = loadWindow & lowMask;
  assign signBit    = (width_q == BYTE) ? loadRaw[7] : loadRaw[15];
  assign loadResult = (sext_q && signBit) ? (loadRaw | ~lowMask) : loadRaw;

  // Store merge: replace bytes o..o+n-1 of the two-word window.
  assign merged = ({w1_q, w0_q} & ~({32'd0, lowMask} << shiftAmt)) |
                  ({32'd0, data_q & lowMask} << shiftAmt);

  always_comb begin
    state_d          = state_q;
    w0_d             = w0_q;
    w1_d             = w1_q;
    err_d            = err_q;
    resp_data_d      = resp_data_q;
    resp_error_d     = resp_error_q;
    accept           = 1'b0;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_write_enable = 1'b0;
    mem_width        = WORD;
    mem_sign_extend  = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    errSoFar         = err_q | mem_alignment_error;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        errSoFar  = err_q;
        if (req_valid) begin
          accept  = 1'b1;
          err_d   = 1'b0;
          state_d = (req_write && !reqMisaligned) ? WR0 : RD0;
        end
      end
      RD0: begin
        err_d = errSoFar;
        if (misaligned) begin
          mem_address = baseAddr;
          w0_d        = mem_data_out;
          state_d     = RD1;
        end else begin
          mem_width       = width_q;
          mem_sign_extend = sext_q;
          mem_address     = addr_q;
          resp_data_d     = mem_data_out;
          resp_error_d    = errSoFar;
          state_d         = DONE;
        end
      end
      RD1: begin
        err_d       = errSoFar;
        mem_address = nextAddr;
        if (write_q) begin
          w1_d    = mem_data_out;
          state_d = WR0;
        end else begin
          resp_data_d  = loadResult;
          resp_error_d = errSoFar;
          state_d      = DONE;
        end
      end
      WR0: begin
        err_d            = errSoFar;
        mem_write_enable = 1'b1;
        if (misaligned) begin
          mem_address = baseAddr;
          mem_data_in = merged[31:0];
          state_d     = WR1;
        end else begin
          mem_width    = width_q;
          mem_address  = addr_q;
          mem_data_in  = data_q;
          resp_data_d  = '0;
          resp_error_d = errSoFar;
          state_d      = DONE;
        end
      end
      WR1: begin
        err_d            = errSoFar;
        mem_write_enable = 1'b1;
        mem_address      = nextAddr;
        mem_data_in      = merged[63:32];
        resp_data_d      = '0;
        resp_error_d     = errSoFar;
        state_d          = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        errSoFar   = err_q;
        state_d    = IDLE;
      end
      default: begin
        errSoFar = err_q;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      width_q      <= WORD;
      sext_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      w0_q         <= '0;
      w1_q         <= '0;
      err_q        <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      w0_q         <= w0_d;
      w1_q         <= w1_d;
      err_q        <= err_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      if (accept) begin
        write_q <= req_write;
        width_q <= req_width;
        sext_q  <= req_sign_extend;
        addr_q  <= req_address;
        data_q  <= req_data;
      end
    end
  end

  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_lsu_align.sv
// Testbench for lsu_align with a 16-byte memory (AddrWidth = 4) so that
// wrap-around of the second word is reachable.
module tb_lsu_align;
  import lsu_align_pkg::*;

  localparam int AW = 4;

  typedef struct {
    logic       write;
    mem_width_t width;
    logic       sext;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } reqT;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  mem_width_t    req_width;
  logic          req_sign_extend;
  logic [AW-1:0] req_address;
  logic [31:0]   req_data;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          resp_error;
  logic          mem_write_enable;
  mem_width_t    mem_width;
  logic          mem_sign_extend;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_in;
  logic [31:0]   memDataOut;
  logic          memAlignErr;

  logic [7:0]  memBytes [16];
  logic [7:0]  refBytes [16];
  logic [31:0] preloadWords [4];
  logic        doPreload = 1'b0;
  logic [15:0] memHalf;
  int          writeCount = 0;
  int          errSeen = 0;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  lsu_align #(.AddrWidth(AW)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_width           (req_width),
    .req_sign_extend     (req_sign_extend),
    .req_address         (req_address),
    .req_data            (req_data),
    .resp_valid          (resp_valid),
    .resp_data           (resp_data),
    .resp_error          (resp_error),
    .mem_write_enable    (mem_write_enable),
    .mem_width           (mem_width),
    .mem_sign_extend     (mem_sign_extend),
    .mem_address         (mem_address),
    .mem_data_in         (mem_data_in),
    .mem_data_out        (memDataOut),
    .mem_alignment_error (memAlignErr)
  );

  // Memory model: combinational read, aligned-only writes on the rising edge.
  always_comb begin
    memDataOut  = '0;
    memAlignErr = 1'b0;
    memHalf     = {memBytes[mem_address + 4'd1], memBytes[mem_address]};
    case (mem_width)
      BYTE: memDataOut = mem_sign_extend ? {{24{memBytes[mem_address][7]}}, memBytes[mem_address]}
                                         : {24'd0, memBytes[mem_address]};
      HALF: begin
        if (mem_address[0]) memAlignErr = 1'b1;
        else memDataOut = mem_sign_extend ? {{16{memHalf[15]}}, memHalf} : {16'd0, memHalf};
      end
      default: begin
        if (mem_address[1:0] != 2'b00) memAlignErr = 1'b1;
        else memDataOut = {memBytes[mem_address + 4'd3], memBytes[mem_address + 4'd2],
                           memBytes[mem_address + 4'd1], memBytes[mem_address]};
      end
    endcase
  end

  always @(posedge clk) begin
    if (memAlignErr) errSeen <= errSeen + 1;
    if (doPreload) begin
      for (int w = 0; w < 4; w++)
        for (int b = 0; b < 4; b++)
          memBytes[4*w+b] <= preloadWords[w][8*b +: 8];
    end else if (mem_write_enable) begin
      writeCount <= writeCount + 1;
      case (mem_width)
        BYTE: memBytes[mem_address] <= mem_data_in[7:0];
        HALF: if (!mem_address[0]) begin
          memBytes[mem_address]        <= mem_data_in[7:0];
          memBytes[mem_address + 4'd1] <= mem_data_in[15:8];
        end
        default: if (mem_address[1:0] == 2'b00) begin
          memBytes[mem_address]        <= mem_data_in[7:0];
          memBytes[mem_address + 4'd1] <= mem_data_in[15:8];
          memBytes[mem_address + 4'd2] <= mem_data_in[23:16];
          memBytes[mem_address + 4'd3] <= mem_data_in[31:24];
        end
      endcase
    end
  end

  // Reference model: a flat byte array, accesses walk n consecutive bytes.
  function automatic int nBytes(mem_width_t w);
    return (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
  endfunction

  function automatic logic [31:0] refLoad(reqT r);
    logic [31:0] v = '0;
    int n = nBytes(r.width);
    for (int i = 0; i < n; i++)
      v = v | (32'(refBytes[(int'(r.addr) + i) % 16]) << (8*i));
    if (r.sext && n < 4 && v[8*n-1])
      v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  function automatic int refLatency(reqT r);
    int n = nBytes(r.width);
    bit mis = (n == 2 && (r.addr % 2) != 0) || (n == 4 && (r.addr % 4) != 0);
    if (!mis) return 2;
    return r.write ? 5 : 3;
  endfunction

  function automatic int refWrites(reqT r);
    if (!r.write) return 0;
    return (refLatency(r) == 5) ? 2 : 1;
  endfunction

  task automatic refStore(reqT r);
    for (int i = 0; i < nBytes(r.width); i++)
      refBytes[(int'(r.addr) + i) % 16] = r.data[8*i +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkMem(input string tag);
    for (int w = 0; w < 4; w++)
      checkOutput($sformatf("%s_mem%0d", tag, w),
                  {memBytes[4*w+3], memBytes[4*w+2], memBytes[4*w+1], memBytes[4*w]},
                  {refBytes[4*w+3], refBytes[4*w+2], refBytes[4*w+1], refBytes[4*w]});
  endtask

  task automatic preload();
    @(negedge clk);
    preloadWords[0] = 32'h1234_5678;
    preloadWords[1] = 32'h0000_1111;
    preloadWords[2] = 32'h1111_0000;
    preloadWords[3] = 32'hb0a0_9080;
    doPreload = 1'b1;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++)
        refBytes[4*w+b] = preloadWords[w][8*b +: 8];
    @(negedge clk);
    doPreload = 1'b0;
  endtask

  task automatic applyStimulus(reqT r);
    req_write       = r.write;
    req_width       = r.width;
    req_sign_extend = r.sext;
    req_address     = r.addr;
    req_data        = r.data;
  endtask

  task automatic scrambleRequest();
    req_write       = 1'($urandom);
    req_width       = mem_width_t'($urandom_range(0, 2));
    req_sign_extend = 1'($urandom);
    req_address     = AW'($urandom);
    req_data        = $urandom;
  endtask

  // Called at a falling edge; returns right after the accepting rising edge.
  task automatic waitAccept();
    int i;
    for (i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) break;
      @(negedge clk);
    end
    if (i == 50) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: req_ready never rose within 50 cycles");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] stopping: request never accepted");
    end
    @(posedge clk);
  endtask

  task automatic sendReq(reqT r);
    @(negedge clk);
    applyStimulus(r);
    req_valid = 1'b1;
    waitAccept();
  endtask

  // Counts cycles after acceptance (cycle 1 = first falling edge).
  task automatic waitResp(input logic hold, input reqT nxt,
                          output logic [31:0] data, output logic err, output int lat);
    bit got = 0;
    data = '0;
    err  = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) applyStimulus(nxt);
        else begin
          req_valid = 1'b0;
          scrambleRequest();
        end
      end
      if (resp_valid === 1'b1) begin
        got  = 1;
        lat  = k;
        data = resp_data;
        err  = resp_error;
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL resp_timeout: observed no resp_valid, expected one within 20 cycles");
    end
  endtask

  task automatic runOp(input reqT r, output logic [31:0] data, output logic err,
                       output int lat, output int writes);
    int wc0;
    reqT dummy;
    dummy = r;
    sendReq(r);
    wc0 = writeCount;
    waitResp(1'b0, dummy, data, err, lat);
    writes = writeCount - wc0;
  endtask

  reqT         r, r2;
  logic [31:0] d;
  logic        e;
  int          lat, writes, wc0, sawResp;

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    scrambleRequest();

    // Reset state
    #1;
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_resp_error", 32'(resp_error), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_write_enable), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_address), 32'd0);
    checkOutput("rst_mem_width", 32'(mem_width), 32'(WORD));
    preload();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);

    // Aligned WORD load at 0
    r = '{1'b0, WORD, 1'b0, 4'd0, 32'd0};
    runOp(r, d, e, lat, writes);
    checkOutput("ld_w0_data", d, 32'h1234_5678);
    checkOutput("ld_w0_lat", 32'(lat), 32'd2);
    checkOutput("ld_w0_err", 32'(e), 32'd0);
    checkOutput("ld_w0_writes", 32'(writes), 32'd0);

    // Misaligned WORD load at 3
    r = '{1'b0, WORD, 1'b0, 4'd3, 32'd0};
    runOp(r, d, e, lat, writes);
    checkOutput("ld_w3_data", d, 32'h0011_1112);
    checkOutput("ld_w3_lat", 32'(lat), 32'd3);

    // Misaligned HALF load at 13, signed and unsigned
    r = '{1'b0, HALF, 1'b1, 4'd13, 32'd0};
    runOp(r, d, e, lat, writes);
    checkOutput("ld_h13s_data", d, 32'hFFFF_A090);
    checkOutput("ld_h13s_lat", 32'(lat), 32'd3);
    r.sext = 1'b0;
    runOp(r, d, e, lat, writes);
    checkOutput("ld_h13u_data", d, 32'h0000_A090);

    // Wrap-around WORD load at 14: words 3 and 0
    r = '{1'b0, WORD, 1'b0, 4'd14, 32'd0};
    runOp(r, d, e, lat, writes);
    checkOutput("ld_wrap_data", d, 32'h5678_b0a0);

    // Misaligned WORD store at 6
    r = '{1'b1, WORD, 1'b0, 4'd6, 32'hDEAD_BEEF};
    runOp(r, d, e, lat, writes);
    checkOutput("st_w6_lat", 32'(lat), 32'd5);
    checkOutput("st_w6_writes", 32'(writes), 32'd2);
    checkOutput("st_w6_data", d, 32'd0);
    checkOutput("st_w6_err", 32'(e), 32'd0);
    checkOutput("st_w6_mem1", {memBytes[7], memBytes[6], memBytes[5], memBytes[4]}, 32'hBEEF_1111);
    checkOutput("st_w6_mem2", {memBytes[11], memBytes[10], memBytes[9], memBytes[8]}, 32'h1111_DEAD);
    refStore(r);
    checkMem("st_w6");

    // Aligned BYTE store then WORD reload
    r = '{1'b1, BYTE, 1'b0, 4'd0, 32'h0000_0077};
    runOp(r, d, e, lat, writes);
    checkOutput("st_b0_lat", 32'(lat), 32'd2);
    checkOutput("st_b0_writes", 32'(writes), 32'd1);
    refStore(r);
    r = '{1'b0, WORD, 1'b0, 4'd0, 32'd0};
    runOp(r, d, e, lat, writes);
    checkOutput("ld_after_b0", d, 32'h1234_5677);

    // Request held on req_valid during a busy period
    preload();
    r  = '{1'b0, WORD, 1'b0, 4'd3, 32'd0};
    r2 = '{1'b0, WORD, 1'b0, 4'd0, 32'd0};
    sendReq(r);
    waitResp(1'b1, r2, d, e, lat);
    checkOutput("held_first_data", d, refLoad(r));
    checkOutput("held_first_lat", 32'(lat), 32'd3);
    checkOutput("held_ready_in_done", 32'(req_ready), 32'd0);
    waitAccept();
    waitResp(1'b0, r2, d, e, lat);
    checkOutput("held_second_data", d, refLoad(r2));
    checkOutput("held_second_lat", 32'(lat), 32'd2);

    // Reset during WR1 of the misaligned store at 6
    preload();
    r = '{1'b1, WORD, 1'b0, 4'd6, 32'hDEAD_BEEF};
    sendReq(r);
    wc0 = writeCount;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("wr1_we", 32'(mem_write_enable), 32'd1);
    checkOutput("wr1_addr", 32'(mem_address), 32'd8);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_we", 32'(mem_write_enable), 32'd0);
    checkOutput("rst_mid_addr", 32'(mem_address), 32'd0);
    sawResp = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) sawResp++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) sawResp++;
    end
    checkOutput("rst_mid_no_resp", 32'(sawResp), 32'd0);
    checkOutput("rst_mid_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_mid_writes", 32'(writeCount - wc0), 32'd1);
    refBytes[6] = r.data[7:0];
    refBytes[7] = r.data[15:8];
    checkMem("rst_mid");

    // Randomized traffic against the byte-array model
    preload();
    for (int i = 0; i < 40; i++) begin
      r.write = 1'($urandom);
      r.width = mem_width_t'($urandom_range(0, 2));
      r.sext  = 1'($urandom);
      r.addr  = AW'($urandom);
      r.data  = $urandom;
      runOp(r, d, e, lat, writes);
      checkOutput($sformatf("rnd%0d_data", i), d, r.write ? 32'd0 : refLoad(r));
      checkOutput($sformatf("rnd%0d_lat", i), 32'(lat), 32'(refLatency(r)));
      checkOutput($sformatf("rnd%0d_err", i), 32'(e), 32'd0);
      checkOutput($sformatf("rnd%0d_writes", i), 32'(writes), 32'(refWrites(r)));
      if (r.write) refStore(r);
    end
    checkMem("rnd_end");

    checkOutput("align_err_seen", 32'(errSeen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
